window_buffer: RTL and testbench
================================

Name: window_buffer

Overview:
- 3x3 pixel window register for the Sobel edge-detection datapath.
- Sits between the pixel-fetch controller, which supplies data_r, and the Sobel gradient unit, which consumes windowBufferOut.
- Fills from single-pixel reads; slides one row/column on a shift command; vacated cells are refilled by subsequent reads.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FILL_VALUE, 0, value written into cells vacated by a shift.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  reset; synchronous, active-high (n_rst=1 at a rising edge resets).
- start_read  input  1  request to load data_r into the current target cell.
- start_shift  input  1  request to shift the window in direction shift_direc.
- shift_direc  input  2  00 down, 01 left, 10 right, 11 up.
- data_r  input  DATA_WIDTH  pixel to load.
- read_done  output  1  one-cycle pulse: pixel loaded.
- shift_done  output  1  one-cycle pulse: shift completed.
- windowBufferOut  output  DATA_WIDTH x 9 (unpacked [0:8])  window, row-major: 0..2 top row, 3..5 middle, 6..8 bottom; index 0 top-left.

Behaviour:
- Reset: all 9 cells = 0, read_done = 0, shift_done = 0, fill pointer = 0, fill mode = FULL, FSM = IDLE.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE -> LOAD when start_read=1.
  - Otherwise IDLE -> SHIFT when start_shift=1.
  - start_read has priority if both requests are high.
  - LOAD and SHIFT return to IDLE after one cycle.
- LOAD:
  - In the IDLE->LOAD edge, data_r is written to target cell and fill pointer advances.
  - read_done = 1 during the LOAD cycle only.
  - A held start_read therefore accepts one pixel every 2 cycles.
- FULL fill order (9 entries): 6,7,8,3,4,5,0,1,2 (bottom row first, left to right).
  - Pointer wraps 8->0.
  - Writes past the 9th restart at cell 6 and overwrite.
- SHIFT:
  - In the IDLE->SHIFT edge the whole window moves in one cycle.
  - left: col0<=col1, col1<=col2, col2<=FILL_VALUE.
  - right: col2<=col1, col1<=col0, col0<=FILL_VALUE.
  - up: row0<=row1, row1<=row2, row2<=FILL_VALUE.
  - down: row2<=row1, row1<=row0, row0<=FILL_VALUE.
  - shift_done = 1 during the SHIFT cycle only.
  - A shift sets fill mode = EDGE and resets the fill pointer to 0.
- EDGE fill order (3 entries) targets the vacated cells:
  - left: 8,5,2.
  - right: 6,3,0.
  - up: 6,7,8.
  - down: 0,1,2.
  - After the 3rd pixel, fill mode returns to FULL with pointer 0.
- Requests arriving while in LOAD or SHIFT are ignored. There is no queuing; requests are re-sampled in IDLE.
- read_done and shift_done are never high in the same cycle.
- Reset asserted mid-operation overrides everything on that edge: cells cleared, pulses cleared, FSM to IDLE.
- windowBufferOut is the direct register value, with no combinational path from inputs.

Optional Feature:
- Macro WINDOW_BUFFER_COUNT_OUT_EN.
- Defined: adds output countOut [3:0] = number of valid pixels loaded since reset or last completed fill, range 0..9.
  - Increments on each LOAD, saturating at 9.
  - A shift sets countOut to 6.
  - Reset sets countOut to 0.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset: n_rst=1 for one edge -> all 9 cells 0; read_done=0; shift_done=0.
- Full fill: nine start_read pulses with data 6,7,8,3,4,5,0,1,2 -> windowBufferOut={0,1,2,3,4,5,6,7,8}; each pulse gives read_done high exactly one cycle after.
- Shift left on full window {0..8}, shift_direc=01 -> {1,2,0,4,5,0,7,8,0}, shift_done one cycle.
  - Then reads 9,10,11 -> cells 8,5,2 = 9,10,11.
- Shift up on {0..8}, shift_direc=11 -> {3,4,5,6,7,8,0,0,0}.
  - Then reads 20,21,22 -> cells 6,7,8.
- Simultaneous start_read=1 and start_shift=1 in IDLE with data 42 -> load only (cell 6 = 42), read_done pulses, no shift.
- Reset mid-fill after 4 loads -> cells all 0; next read lands in cell 6.
  - With WINDOW_BUFFER_COUNT_OUT_EN: countOut 4->0.

Source files
------------

// File: rtl/window_buffer.sv
// ---------------------------------------------------------------------------
// window_buffer
//   3x3 pixel window register between the pixel-fetch controller and the
//   Sobel gradient unit. Single-pixel reads fill the window. A shift command
//   slides it one row or column and leaves the vacated edge at FILL_VALUE.
//   Later reads then refill that vacated edge.
//
// Parameters
//   DATA_WIDTH  pixel width in bits
//   FILL_VALUE  value written into cells vacated by a shift
//
// Ports
//   clk              rising-edge clock
//   n_rst            synchronous reset, active HIGH despite the name
//   start_read       load data_r into the current target cell
//   start_shift      shift window in direction shift_direc
//   shift_direc      00 down, 01 left, 10 right, 11 up
//   data_r           pixel to load
//   read_done        one-cycle pulse: pixel loaded (LOAD state)
//   shift_done       one-cycle pulse: shift completed (SHIFT state)
//   countOut         [only with WINDOW_BUFFER_COUNT_OUT_EN] loaded-pixel
//                    count, saturates at 9, set to 6 by a shift
//   windowBufferOut  window, row-major, [0] = top-left, [8] = bottom-right
//
// Optional feature macro: WINDOW_BUFFER_COUNT_OUT_EN
// ---------------------------------------------------------------------------
module window_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start_read,
    input  logic                  start_shift,
    input  logic [1:0]            shift_direc,
    input  logic [DATA_WIDTH-1:0] data_r,
    output logic                  read_done,
    output logic                  shift_done,
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
    output logic [3:0]            countOut,
`endif
    output logic [DATA_WIDTH-1:0] windowBufferOut [0:8]
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    state_t                state;
    logic [DATA_WIDTH-1:0] win     [0:8];
    logic [DATA_WIDTH-1:0] shifted [0:8];
    logic [3:0]            fill_ptr;
    logic                  edge_mode;   // 0: FULL order, 1: refill vacated edge
    logic [1:0]            edge_dir;    // direction of the shift that vacated the edge
    logic [3:0]            tgt;
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
    logic [3:0]            count;
`endif

    // Target cell for the next read.
    // FULL mode fills the bottom row first: 6,7,8,3,4,5,0,1,2.
    // EDGE mode fills only the three cells that the last shift vacated.
    always_comb begin
        tgt = 4'd6;
        if (edge_mode) begin
            unique case (edge_dir)
                DIR_LEFT:  tgt = 4'd8 - 4'd3 * fill_ptr;  // 8,5,2
                DIR_RIGHT: tgt = 4'd6 - 4'd3 * fill_ptr;  // 6,3,0
                DIR_UP:    tgt = 4'd6 + fill_ptr;         // 6,7,8
                default:   tgt = fill_ptr;                // down: 0,1,2
            endcase
        end else begin
            case (fill_ptr)
                4'd0:    tgt = 4'd6;
                4'd1:    tgt = 4'd7;
                4'd2:    tgt = 4'd8;
                4'd3:    tgt = 4'd3;
                4'd4:    tgt = 4'd4;
                4'd5:    tgt = 4'd5;
                4'd6:    tgt = 4'd0;
                4'd7:    tgt = 4'd1;
                default: tgt = 4'd2;
            endcase
        end
    end

    // Whole-window shift result. The incoming edge takes FILL_VALUE.
    always_comb begin
        for (int i = 0; i < 9; i++) shifted[i] = FILL_VALUE;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                unique case (shift_direc)
                    DIR_LEFT:  if (c < 2) shifted[3*r+c] = win[3*r+c+1];
                    DIR_RIGHT: if (c > 0) shifted[3*r+c] = win[3*r+c-1];
                    DIR_UP:    if (r < 2) shifted[3*r+c] = win[3*(r+1)+c];
                    default:   if (r > 0) shifted[3*r+c] = win[3*(r-1)+c];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state      <= IDLE;
            read_done  <= 1'b0;
            shift_done <= 1'b0;
            fill_ptr   <= '0;
            edge_mode  <= 1'b0;
            edge_dir   <= DIR_DOWN;
            for (int i = 0; i < 9; i++) win[i] <= '0;
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
            count      <= '0;
`endif
        end else begin
            read_done  <= 1'b0;
            shift_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A read wins over a shift when both are requested.
                    if (start_read) begin
                        win[tgt]  <= data_r;
                        read_done <= 1'b1;
                        state     <= LOAD;
                        if (edge_mode) begin
                            if (fill_ptr == 4'd2) begin
                                edge_mode <= 1'b0;
                                fill_ptr  <= '0;
                            end else begin
                                fill_ptr  <= fill_ptr + 4'd1;
                            end
                        end else begin
                            fill_ptr <= (fill_ptr == 4'd8) ? 4'd0 : fill_ptr + 4'd1;
                        end
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
                        if (count != 4'd9) count <= count + 4'd1;
`endif
                    end else if (start_shift) begin
                        win        <= shifted;
                        shift_done <= 1'b1;
                        state      <= SHIFT;
                        edge_mode  <= 1'b1;
                        edge_dir   <= shift_direc;
                        fill_ptr   <= '0;
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
                        count      <= 4'd6;
`endif
                    end
                end
                // Requests seen in LOAD or SHIFT are dropped. No queuing.
                default: state <= IDLE;
            endcase
        end
    end

    assign windowBufferOut = win;
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
    assign countOut = count;
`endif

endmodule

// File: tb/tb_window_buffer.sv
module tb_window_buffer;
    localparam int DW = 8;
    typedef logic [8:0][DW-1:0] win_t;
    typedef struct packed {
        logic is_shift;
        win_t w;
    } exp_t;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start_read;
    logic          start_shift;
    logic [1:0]    shift_direc;
    logic [DW-1:0] data_r;
    logic          read_done;
    logic          shift_done;
    logic [DW-1:0] wout [0:8];
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
    logic [3:0]    countOut;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t mon_e;
    int   ord [9] = '{6, 7, 8, 3, 4, 5, 0, 1, 2};

    always #5 clk = ~clk;

    window_buffer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .n_rst(n_rst), .start_read(start_read), .start_shift(start_shift),
        .shift_direc(shift_direc), .data_r(data_r), .read_done(read_done),
        .shift_done(shift_done),
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        .countOut(countOut),
`endif
        .windowBufferOut(wout)
    );

    function automatic win_t win9(int c0, int c1, int c2, int c3, int c4,
                                  int c5, int c6, int c7, int c8);
        win_t w;
        w[0] = DW'(c0); w[1] = DW'(c1); w[2] = DW'(c2);
        w[3] = DW'(c3); w[4] = DW'(c4); w[5] = DW'(c5);
        w[6] = DW'(c6); w[7] = DW'(c7); w[8] = DW'(c8);
        return w;
    endfunction

    function automatic win_t dut_win();
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = wout[i];
        return w;
    endfunction

    task automatic check_win(input string name, input win_t want);
        win_t got;
        got = dut_win();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (read_done === 1'b1 && shift_done === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL both_pulses: read_done=1 shift_done=1 want at most one");
        end else if (read_done === 1'b1 || shift_done === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: read_done=%0b shift_done=%0b want none",
                         read_done, shift_done);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.is_shift !== shift_done || mon_e.w !== dut_win()) begin
                    n_fail++;
                    $display("FAIL %s_window: got %h (shift_done=%0b) want %h (shift=%0b)",
                             mon_e.is_shift ? "shift" : "read", dut_win(), shift_done,
                             mon_e.w, mon_e.is_shift);
                end
            end
        end
    end

    task automatic expect_op(input logic is_shift, input win_t w);
        exp_t e;
        e.is_shift = is_shift;
        e.w        = w;
        q.push_back(e);
    endtask

    // The pulse must arrive in the cycle right after the request edge.
    task automatic check_latency(input string name);
        @(posedge clk);
        #1;
        check_val(name, q.size(), 0);
        q.delete();
    endtask

    task automatic do_read(input int d, input win_t w);
        @(negedge clk);
        start_read = 1'b1;
        data_r     = DW'(d);
        expect_op(1'b0, w);
        @(negedge clk);
        start_read = 1'b0;
        check_latency("read_latency");
    endtask

    task automatic do_shift(input logic [1:0] dir, input win_t w);
        @(negedge clk);
        start_shift = 1'b1;
        shift_direc = dir;
        expect_op(1'b1, w);
        @(negedge clk);
        start_shift = 1'b0;
        check_latency("shift_latency");
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst       = 1'b1;
        start_read  = 1'b0;
        start_shift = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        check_win("reset_window", '0);
        check_val("reset_read_done", int'(read_done), 0);
        check_val("reset_shift_done", int'(shift_done), 0);
    endtask

    // Data equals the destination index, so the full window reads 0..8.
    task automatic fill_full();
        win_t cur;
        cur = '0;
        for (int i = 0; i < 9; i++) begin
            cur[ord[i]] = DW'(ord[i]);
            do_read(ord[i], cur);
        end
    endtask

    initial begin
        n_rst = 1'b1; start_read = 1'b0; start_shift = 1'b0;
        shift_direc = 2'b00; data_r = '0;

        do_reset();
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        check_val("count_reset", int'(countOut), 0);
`endif
        // Full fill, then shift left and refill the right column.
        fill_full();
        check_win("full_window", win9(0, 1, 2, 3, 4, 5, 6, 7, 8));
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        check_val("count_full", int'(countOut), 9);
`endif
        do_shift(2'b01, win9(1, 2, 0, 4, 5, 0, 7, 8, 0));
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        check_val("count_shift", int'(countOut), 6);
`endif
        do_read(9,  win9(1, 2, 0, 4, 5, 0, 7, 8, 9));
        do_read(10, win9(1, 2, 0, 4, 5, 10, 7, 8, 9));
        do_read(11, win9(1, 2, 11, 4, 5, 10, 7, 8, 9));
        // Edge refill done: back to FULL order at cell 6.
        do_read(50, win9(1, 2, 11, 4, 5, 10, 50, 8, 9));

        // Shift up, refill bottom row.
        do_reset();
        fill_full();
        do_shift(2'b11, win9(3, 4, 5, 6, 7, 8, 0, 0, 0));
        do_read(20, win9(3, 4, 5, 6, 7, 8, 20, 0, 0));
        do_read(21, win9(3, 4, 5, 6, 7, 8, 20, 21, 0));
        do_read(22, win9(3, 4, 5, 6, 7, 8, 20, 21, 22));

        // Shift right, first refill lands in cell 6.
        do_reset();
        fill_full();
        do_shift(2'b10, win9(0, 0, 1, 0, 3, 4, 0, 6, 7));
        do_read(30, win9(0, 0, 1, 0, 3, 4, 30, 6, 7));

        // Tenth write wraps onto cell 6, then shift down.
        do_reset();
        fill_full();
        do_read(99, win9(0, 1, 2, 3, 4, 5, 99, 7, 8));
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        check_val("count_saturate", int'(countOut), 9);
`endif
        do_shift(2'b00, win9(0, 0, 0, 0, 1, 2, 3, 4, 5));
        do_read(40, win9(40, 0, 0, 0, 1, 2, 3, 4, 5));

        // Read and shift requested together: the read wins.
        do_reset();
        @(negedge clk);
        start_read = 1'b1; start_shift = 1'b1; shift_direc = 2'b01; data_r = 8'd42;
        expect_op(1'b0, win9(0, 0, 0, 0, 0, 0, 42, 0, 0));
        @(negedge clk);
        start_read = 1'b0; start_shift = 1'b0;
        check_latency("simul_latency");
        @(negedge clk);
        check_win("simul_no_shift", win9(0, 0, 0, 0, 0, 0, 42, 0, 0));

        // Reset mid-fill overrides a concurrent read.
        do_reset();
        do_read(11, win9(0, 0, 0, 0, 0, 0, 11, 0, 0));
        do_read(12, win9(0, 0, 0, 0, 0, 0, 11, 12, 0));
        do_read(13, win9(0, 0, 0, 0, 0, 0, 11, 12, 13));
        do_read(14, win9(0, 0, 0, 14, 0, 0, 11, 12, 13));
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        check_val("count_four", int'(countOut), 4);
`endif
        @(negedge clk);
        n_rst = 1'b1; start_read = 1'b1; data_r = 8'd99;
        @(negedge clk);
        n_rst = 1'b0; start_read = 1'b0;
        check_win("midreset_window", '0);
        check_val("midreset_read_done", int'(read_done), 0);
`ifdef WINDOW_BUFFER_COUNT_OUT_EN
        check_val("count_midreset", int'(countOut), 0);
`endif
        do_read(77, win9(0, 0, 0, 0, 0, 0, 77, 0, 0));

        repeat (3) @(negedge clk);
        check_val("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
